// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the serial add/subtract engine: FSM and mode encodings,
// debug view of the controller, and step/counter sizing helpers.
package serial_addsub_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Debug view: latched operation plus current controller state.
    typedef struct packed {
        logic   mode;
        state_e state;
    } dbg_t;

    function automatic int calc_steps(input int width, input int digit);
        return width / digit;
    endfunction

    // A one-step engine still needs a 1-bit counter, hence the floor of 1.
    function automatic int calc_cnt_w(input int steps);
        return (steps <= 2) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full-adder cell; the building block of the digit ripple chain.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_addsub_digit_adder.sv
// Combinational DIGIT-bit ripple adder. Also reports the carry entering the
// top bit so the caller can form signed overflow on the most significant digit.
module serial_addsub_digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    input  logic             cin_i,
    output logic [DIGIT-1:0] sum_o,
    output logic             cout_o,
    output logic             ctop_o
);

    logic [DIGIT:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        full_adder u_fa (
            .a_i  (a_i[i]),
            .b_i  (b_i[i]),
            .ci_i (carry[i]),
            .s_o  (sum_o[i]),
            .co_o (carry[i+1])
        );
    end

    assign cout_o = carry[DIGIT];
    assign ctop_o = carry[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract engine: processes DIGIT bits per clock with the
// carry held in a register between digits. Start/busy/done handshake.
//
// Handshake: start is accepted on any rising edge where busy=0 (including the
// done cycle, giving back-to-back operation). done pulses for one cycle and
// sum/cout/ovf update on that same edge; they are held until the next completion.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output dbg_t             dbg_o
);

    localparam int STEPS = calc_steps(WIDTH, DIGIT);
    localparam int CW    = calc_cnt_w(STEPS);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, mode_q, mode_d;
    logic             cout_q, cout_d, ovf_q, ovf_d, done_q, done_d;

    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout, dig_ctop;
    logic [WIDTH-1:0] res_next;
    logic             unused_res;

    serial_addsub_digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a_i    (a_q[DIGIT-1:0]),
        .b_i    (b_q[DIGIT-1:0]),
        .cin_i  (carry_q),
        .sum_o  (dig_sum),
        .cout_o (dig_cout),
        .ctop_o (dig_ctop)
    );

    // New digit enters at the top; after STEPS shifts res_next holds the full result.
    if (DIGIT == WIDTH) begin : g_res_full
        assign res_next = dig_sum;
    end else begin : g_res_part
        assign res_next = {dig_sum, res_q[WIDTH-1:DIGIT]};
    end
    assign unused_res = ^res_q[DIGIT-1:0];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtract as a + ~b + ~borrow_in.
                    a_d     = a;
                    b_d     = (mode == MODE_SUB) ? ~b : b;
                    carry_d = (mode == MODE_SUB) ? ~cin : cin;
                    mode_d  = mode;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_next;
                carry_d = dig_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    sum_d   = res_next;
                    cout_d  = dig_cout;
                    ovf_d   = dig_ctop ^ dig_cout;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            mode_q  <= MODE_ADD;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = done_q;
    assign sum         = sum_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;
    assign dbg_o.mode  = mode_q;
    assign dbg_o.state = state_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: a 16-bit/4-bit-digit instance and an 8-bit/1-bit-digit
// instance, checked against an integer-arithmetic reference model.
module tb_serial_addsub;

    localparam int S16 = 4;
    localparam int S8  = 8;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start16, mode16, cin16, busy16, done16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;
    logic [1:0]  dbg16;
    logic        start8, mode8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;
    logic [1:0]  dbg8;

    int checks = 0;
    int errors = 0;
    int done16_cnt = 0;

    // scoreboard entries: {cout, ovf, sum (zero-extended to 16)}
    logic [17:0] exp_q[$];
    logic [17:0] exp8_q[$];
    logic [17:0] last16 = '0;
    logic [17:0] last8  = '0;

    always @(negedge clk) if (done16 === 1'b1) done16_cnt++;

    serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .mode(mode16), .a(a16), .b(b16),
        .cin(cin16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16),
        .ovf(ovf16), .dbg_o(dbg16)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
        .ovf(ovf8), .dbg_o(dbg8)
    );

    // reference model: plain integer arithmetic on unsigned and signed views
    function automatic logic [17:0] model(input int w, input logic m,
                                          input logic [15:0] a, input logic [15:0] b,
                                          input logic c);
        int ua, ub, sa, sb, ci, r, sr;
        logic co, ov;
        logic [15:0] mask;
        ua = int'(a);
        ub = int'(b);
        ci = c ? 1 : 0;
        sa = a[w-1] ? ua - (1 << w) : ua;
        sb = b[w-1] ? ub - (1 << w) : ub;
        if (m == 1'b0) begin
            r  = ua + ub + ci;
            co = (r >= (1 << w));
            sr = sa + sb + ci;
        end else begin
            r  = ua - ub - ci;
            co = (ua >= ub + ci);
            sr = sa - sb - ci;
        end
        ov   = (sr >= (1 << (w - 1))) || (sr < -(1 << (w - 1)));
        mask = 16'((1 << w) - 1);
        return {co, ov, 16'(r) & mask};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks: called at a negedge, return just after the start edge
    task automatic op16(input logic m, input logic [15:0] a, input logic [15:0] b, input logic c);
        mode16 = m; a16 = a; b16 = b; cin16 = c; start16 = 1'b1;
        exp_q.push_back(model(16, m, a, b, c));
        @(posedge clk);
        #1 start16 = 1'b0;
    endtask

    task automatic op8(input logic m, input logic [7:0] a, input logic [7:0] b, input logic c);
        mode8 = m; a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        exp8_q.push_back(model(8, m, {8'h00, a}, {8'h00, b}, c));
        @(posedge clk);
        #1 start8 = 1'b0;
    endtask

    // waits for done (bounded), scrambling inputs meanwhile; returns at the done negedge
    task automatic finish16(input string tag, input bit poke);
        int k, busy_n;
        bit held;
        logic [17:0] e;
        k = 0; busy_n = 0; held = 1'b1;
        @(negedge clk);
        while (done16 !== 1'b1 && k < 40) begin
            if (busy16 === 1'b1) busy_n++;
            if (sum16 !== last16[15:0] || {cout16, ovf16} !== last16[17:16]) held = 1'b0;
            a16 = 16'($urandom); b16 = 16'($urandom);
            mode16 = 1'($urandom); cin16 = 1'($urandom);
            start16 = poke && (k == 1);
            k++;
            @(negedge clk);
        end
        start16 = 1'b0;
        e = exp_q.pop_front();
        check({tag, " latency"}, k, S16);
        check({tag, " busy_cycles"}, busy_n, S16);
        check({tag, " held"}, 32'(held), 1);
        check({tag, " sum"}, sum16, e[15:0]);
        check({tag, " busy/cout/ovf"}, {busy16, cout16, ovf16}, {1'b0, e[17:16]});
        last16 = e;
    endtask

    task automatic finish8(input string tag);
        int k;
        bit held;
        logic [17:0] e;
        k = 0; held = 1'b1;
        @(negedge clk);
        while (done8 !== 1'b1 && k < 40) begin
            if (busy8 !== 1'b1 || sum8 !== last8[7:0] || {cout8, ovf8} !== last8[17:16]) held = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom);
            mode8 = 1'($urandom); cin8 = 1'($urandom);
            k++;
            @(negedge clk);
        end
        e = exp8_q.pop_front();
        check({tag, " latency"}, k, S8);
        check({tag, " busy_held"}, 32'(held), 1);
        check({tag, " sum"}, sum8, e[7:0]);
        check({tag, " busy/cout/ovf"}, {busy8, cout8, ovf8}, {1'b0, e[17:16]});
        last8 = e;
    endtask

    initial begin
        int base;
        rst = 1'b1;
        start16 = 1'b0; mode16 = 1'b0; cin16 = 1'b0; a16 = '0; b16 = '0;
        start8 = 1'b0; mode8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        check("reset16 ctl", {busy16, done16, cout16, ovf16, dbg16}, 6'b0);
        check("reset16 sum", sum16, 16'h0000);
        check("reset8 ctl", {busy8, done8, cout8, ovf8, dbg8}, 6'b0);
        check("reset8 sum", sum8, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        // directed arithmetic corners
        op16(1'b0, 16'h1234, 16'h0FF1, 1'b0); finish16("add_basic", 1'b0);
        check("add_basic sum_const", sum16, 16'h2225);
        @(negedge clk);
        check("done_one_cycle", 32'(done16), 0);
        op16(1'b0, 16'h7FFF, 16'h0001, 1'b0); finish16("add_ovf", 1'b0);
        check("add_ovf const", {cout16, ovf16, sum16}, {2'b01, 16'h8000});
        @(negedge clk);
        op16(1'b0, 16'hFFFF, 16'h0001, 1'b0); finish16("add_wrap", 1'b0);
        check("add_wrap const", {cout16, ovf16, sum16}, {2'b10, 16'h0000});
        @(negedge clk);
        op16(1'b1, 16'h0005, 16'h0007, 1'b0); finish16("sub_borrow", 1'b0);
        check("sub_borrow const", {cout16, ovf16, sum16}, {2'b00, 16'hFFFE});
        @(negedge clk);
        op16(1'b1, 16'h8000, 16'h0001, 1'b0); finish16("sub_ovf", 1'b0);
        check("sub_ovf const", {cout16, ovf16, sum16}, {2'b11, 16'h7FFF});
        @(negedge clk);

        // start during RUN is ignored
        op16(1'b0, 16'h1111, 16'h2222, 1'b0); finish16("ignore_start", 1'b1);
        check("ignore_start const", sum16, 16'h3333);
        @(negedge clk);
        check("ignore_start idle", 32'(busy16), 0);

        // back-to-back: start in the done cycle
        op16(1'b0, 16'h0100, 16'h0023, 1'b1); finish16("b2b_first", 1'b0);
        op16(1'b1, 16'h0050, 16'h0060, 1'b1); finish16("b2b_second", 1'b0);
        @(negedge clk);

        // reset on the 2nd RUN cycle aborts the operation
        op16(1'b0, 16'h4321, 16'h1111, 1'b0);
        void'(exp_q.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort ctl", {busy16, cout16, ovf16, dbg16}, 5'b0);
        check("abort sum", sum16, 16'h0000);
        last16 = '0;
        last8  = '0;
        base = done16_cnt;
        repeat (10) @(negedge clk);
        check("abort no_done", done16_cnt - base, 0);

        // randomized 16-bit operations, mixing back-to-back and gapped starts
        for (int i = 0; i < 20; i++) begin
            op16(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
            finish16("rand16", 1'($urandom));
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        // 8-bit, one bit per clock
        op8(1'b0, 8'hFF, 8'h01, 1'b1); finish8("add8_carry");
        check("add8_carry const", {cout8, ovf8, sum8}, {2'b10, 8'h01});
        @(negedge clk);
        op8(1'b1, 8'h80, 8'h01, 1'b0); finish8("sub8_ovf");
        for (int i = 0; i < 12; i++) begin
            op8(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            finish8("rand8");
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
